gb_frame_ctrl: RTL and testbench
================================

GB_FRAME_CTRL -- requirements
Module: gb_frame_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
- IN_PIX, 316224, input pixels per frame (488x648).
- OUT_PIX, 307200, output pixels per frame (480x640).
- TIMEOUT, 4096, stall cycles before abort.
REQ-002 Ports (name direction width meaning):
- ap_clk in 1: clock. This block has one clock.
- ap_rst_n in 1: reset, asynchronous and active-low.
- start in 1: frame request pulse.
- busy out 1: frame in progress.
- done out 1: one-cycle frame-complete pulse.
- err out 1: sticky error flag.
- m_awvalid out 1 / m_awready in 1 / m_awaddr out 5: AXI-lite write address to the accelerator config port.
- m_wvalid out 1 / m_wready in 1 / m_wdata out 32 / m_wstrb out 4: AXI-lite write data.
- m_bvalid in 1 / m_bready out 1 / m_bresp in 2: AXI-lite write response.
- src_tdata in 8 / src_tvalid in 1 / src_tready out 1: upstream pixel stream.
- acc_in_tdata out 8 / acc_in_tvalid out 1 / acc_in_tready in 1 / acc_in_tlast out 1: accelerator arg_1 stream.
- acc_out_tdata in 8 / acc_out_tvalid in 1 / acc_out_tready out 1: accelerator arg_0 stream.
- dst_tdata out 8 / dst_tvalid out 1 / dst_tready in 1: downstream pixel stream.

Function
REQ-003 FSM states: IDLE, CFG, RESP, RUN, DRAIN, FIN, ERR; busy=1 in every state except IDLE and ERR.
REQ-004 IDLE->CFG on start=1; start is ignored in all other states.
REQ-005 CFG: m_awvalid=m_wvalid=1, m_awaddr=5'h00, m_wdata=32'h1 (ap_start), m_wstrb=4'hF. Each valid drops independently the cycle after its own handshake; when both handshakes are done -> RESP.
REQ-006 RESP: m_bready=1; on m_bvalid go to RUN if m_bresp==2'b00, otherwise go to ERR.
REQ-007 RUN/DRAIN input path is a combinational pass-through:
- acc_in_tdata=src_tdata.
- acc_in_tvalid=src_tvalid & gate_in.
- src_tready=acc_in_tready & gate_in.
- gate_in=1 while in_cnt<IN_PIX.
REQ-008 in_cnt (19 bits) increments on each acc_in handshake. acc_in_tlast=1 exactly when in_cnt==IN_PIX-1.
REQ-009 Output path is a combinational pass-through gated by out_cnt<OUT_PIX. out_cnt (19 bits) increments on each dst handshake.
REQ-010 RUN->DRAIN on the cycle in_cnt reaches IN_PIX. DRAIN->FIN on the cycle out_cnt reaches OUT_PIX.
REQ-011 If the last input and last output handshakes complete in the same cycle, go RUN->FIN directly.
REQ-012 FIN: done=1 for exactly one cycle, both counters clear, then ->IDLE.
REQ-013 Counters never wrap; handshakes beyond the frame count are blocked by the gating.
REQ-014 ERR: all valids and readies are 0 and err=1. A start pulse clears err, clears both counters and goes to CFG.
REQ-015 Latency: m_awvalid rises 1 cycle after start. done rises 1 cycle after the final dst handshake.

Reset
REQ-016 On ap_rst_n=0, asynchronously:
- state=IDLE; in_cnt=out_cnt=0.
- err=0, done=0, busy=0.
- All AXI valid/ready outputs=0.
REQ-017 Reset asserted mid-frame aborts the frame with no done pulse. After release, the block waits in IDLE for start.

Configuration
REQ-018 Macro GB_FRAME_CTRL_TIMEOUT_EN enables a watchdog.
- With the macro: a 13-bit stall counter clears on any acc_in or dst handshake and increments in RUN and DRAIN otherwise. On reaching TIMEOUT the FSM goes to ERR.
- Without the macro: no watchdog; ERR is reachable only through a non-OKAY bresp.

Verification
REQ-019 Required directed scenarios:
- Nominal frame, IN_PIX=16, OUT_PIX=9, all readies held 1 -> one AW/W write (addr 0, data 1); acc_in_tlast on the 16th input beat; done pulse 1 cycle after the 9th dst beat; busy then 0.
- m_awready delayed 3 cycles, m_wready immediate -> m_wvalid drops after 1 cycle; m_awvalid holds 4 cycles; FSM stays in CFG until both handshakes are done.
- m_bresp=2'b10 -> err=1, busy=0, no stream traffic. A later start -> err=0 and a new CFG write.
- src_tvalid held 1 after 16 input beats -> src_tready=0 from then on; in_cnt stays 16.
- Reset pulsed at in_cnt=7 -> all outputs go 0 immediately, no done pulse, and the next start runs a full frame.
- With GB_FRAME_CTRL_TIMEOUT_EN, TIMEOUT=32, acc_out_tvalid held 0 in DRAIN -> err=1 after 32 stall cycles.

Source files
------------

// File: rtl/gb_frame_ctrl.sv
// Frame controller: starts the accelerator over AXI-lite, then meters one frame of pixels in and out.
// Optional stall watchdog enabled by defining GB_FRAME_CTRL_TIMEOUT_EN.
module gb_frame_ctrl #(
  parameter int unsigned IN_PIX  = 316224,
  parameter int unsigned OUT_PIX = 307200,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [4:0]  m_awaddr,
  output logic        m_wvalid,
  input  logic        m_wready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_bvalid,
  output logic        m_bready,
  input  logic [1:0]  m_bresp,
  input  logic [7:0]  src_tdata,
  input  logic        src_tvalid,
  output logic        src_tready,
  output logic [7:0]  acc_in_tdata,
  output logic        acc_in_tvalid,
  input  logic        acc_in_tready,
  output logic        acc_in_tlast,
  input  logic [7:0]  acc_out_tdata,
  input  logic        acc_out_tvalid,
  output logic        acc_out_tready,
  output logic [7:0]  dst_tdata,
  output logic        dst_tvalid,
  input  logic        dst_tready
);

  localparam int unsigned CNT_W = 19;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_RESP,
    S_RUN,
    S_DRAIN,
    S_FIN,
    S_ERR
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_in_cnt;
  logic [CNT_W-1:0]   r_out_cnt;
  logic [CNT_W-1:0]   w_in_cnt_nxt;
  logic [CNT_W-1:0]   w_out_cnt_nxt;
  logic               r_awvalid;
  logic               r_wvalid;
  logic               r_bready;
  logic               r_aw_done;
  logic               r_w_done;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic               w_awvalid_nxt;
  logic               w_wvalid_nxt;
  logic               w_bready_nxt;
  logic               w_aw_done_nxt;
  logic               w_w_done_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic               w_err_nxt;

  logic               w_stream;
  logic               w_gate_in;
  logic               w_gate_out;
  logic               w_in_hs;
  logic               w_out_hs;
  logic               w_in_last;
  logic               w_out_full;
  logic               w_aw_hs;
  logic               w_w_hs;
  logic               w_timeout;

  // Stream gating: pixels pass only while the frame is running and its count is not yet met
  assign w_stream   = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_gate_in  = w_stream && (r_in_cnt < CNT_W'(IN_PIX));
  assign w_gate_out = w_stream && (r_out_cnt < CNT_W'(OUT_PIX));
  assign w_in_hs    = src_tvalid & acc_in_tready & w_gate_in;
  assign w_out_hs   = acc_out_tvalid & dst_tready & w_gate_out;
  assign w_in_last  = w_in_hs && (r_in_cnt == CNT_W'(IN_PIX - 1));
  assign w_out_full = (r_out_cnt == CNT_W'(OUT_PIX)) ||
                      (w_out_hs && (r_out_cnt == CNT_W'(OUT_PIX - 1)));
  assign w_aw_hs    = r_awvalid & m_awready;
  assign w_w_hs     = r_wvalid & m_wready;

  assign acc_in_tdata   = src_tdata;
  assign acc_in_tvalid  = src_tvalid & w_gate_in;
  assign src_tready     = acc_in_tready & w_gate_in;
  assign acc_in_tlast   = w_stream && (r_in_cnt == CNT_W'(IN_PIX - 1));
  assign dst_tdata      = acc_out_tdata;
  assign dst_tvalid     = acc_out_tvalid & w_gate_out;
  assign acc_out_tready = dst_tready & w_gate_out;

  assign m_awvalid = r_awvalid;
  assign m_awaddr  = 5'h00;
  assign m_wvalid  = r_wvalid;
  assign m_wdata   = 32'h0000_0001;
  assign m_wstrb   = 4'hF;
  assign m_bready  = r_bready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

`ifdef GB_FRAME_CTRL_TIMEOUT_EN
  localparam int unsigned STALL_W = 13;

  logic [STALL_W-1:0] r_stall;
  logic               w_stall_inc;

  assign w_stall_inc = w_stream & ~w_in_hs & ~w_out_hs;
  assign w_timeout   = w_stall_inc && (r_stall == STALL_W'(TIMEOUT - 1));

  // Stall counter: any pixel movement restarts the count
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_stall <= '0;
    end else if (w_stall_inc) begin
      r_stall <= r_stall + STALL_W'(1);
    end else begin
      r_stall <= '0;
    end
  end
`else
  assign w_timeout = 1'b0 & (TIMEOUT == 0);
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state   <= S_IDLE;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_in_cnt  <= w_in_cnt_nxt;
      r_out_cnt <= w_out_cnt_nxt;
      r_awvalid <= w_awvalid_nxt;
      r_wvalid  <= w_wvalid_nxt;
      r_bready  <= w_bready_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Next state; status flags are registered from the next state so they align with it
  always_comb begin
    w_state_nxt   = r_state;
    w_awvalid_nxt = r_awvalid;
    w_wvalid_nxt  = r_wvalid;
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;
    w_bready_nxt  = 1'b0;
    w_in_cnt_nxt  = r_in_cnt + CNT_W'(w_in_hs);
    w_out_cnt_nxt = r_out_cnt + CNT_W'(w_out_hs);

    unique case (r_state)
      S_IDLE, S_ERR: begin
        if (start) begin
          w_state_nxt   = S_CFG;
          w_awvalid_nxt = 1'b1;
          w_wvalid_nxt  = 1'b1;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
          w_in_cnt_nxt  = '0;
          w_out_cnt_nxt = '0;
        end
      end
      S_CFG: begin
        if (w_aw_hs) begin
          w_awvalid_nxt = 1'b0;
          w_aw_done_nxt = 1'b1;
        end
        if (w_w_hs) begin
          w_wvalid_nxt = 1'b0;
          w_w_done_nxt = 1'b1;
        end
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
          w_state_nxt  = S_RESP;
          w_bready_nxt = 1'b1;
        end
      end
      S_RESP: begin
        w_bready_nxt = 1'b1;
        if (m_bvalid) begin
          w_bready_nxt = 1'b0;
          w_state_nxt  = (m_bresp == 2'b00) ? S_RUN : S_ERR;
        end
      end
      S_RUN: begin
        if (w_timeout) begin
          w_state_nxt = S_ERR;
        end else if (w_in_last) begin
          w_state_nxt = w_out_full ? S_FIN : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_timeout) begin
          w_state_nxt = S_ERR;
        end else if (w_out_full) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        w_state_nxt   = S_IDLE;
        w_in_cnt_nxt  = '0;
        w_out_cnt_nxt = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_ERR);
    w_done_nxt = (w_state_nxt == S_FIN);
    w_err_nxt  = (w_state_nxt == S_ERR);
  end

endmodule

// File: tb/tb_gb_frame_ctrl.sv
// Directed bench for gb_frame_ctrl with a 16-in / 9-out frame.
module tb_gb_frame_ctrl;

  logic        ap_clk;
  logic        ap_rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic        err;
  logic        m_awvalid;
  logic        m_awready;
  logic [4:0]  m_awaddr;
  logic        m_wvalid;
  logic        m_wready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_bvalid;
  logic        m_bready;
  logic [1:0]  m_bresp;
  logic [7:0]  src_tdata;
  logic        src_tvalid;
  logic        src_tready;
  logic [7:0]  acc_in_tdata;
  logic        acc_in_tvalid;
  logic        acc_in_tready;
  logic        acc_in_tlast;
  logic [7:0]  acc_out_tdata;
  logic        acc_out_tvalid;
  logic        acc_out_tready;
  logic [7:0]  dst_tdata;
  logic        dst_tvalid;
  logic        dst_tready;

  int checks   = 0;
  int errors   = 0;
  int aw_hs    = 0;
  int w_hs     = 0;
  int done_cnt = 0;

  gb_frame_ctrl #(
    .IN_PIX (16),
    .OUT_PIX(9),
    .TIMEOUT(32)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .m_awvalid     (m_awvalid),
    .m_awready     (m_awready),
    .m_awaddr      (m_awaddr),
    .m_wvalid      (m_wvalid),
    .m_wready      (m_wready),
    .m_wdata       (m_wdata),
    .m_wstrb       (m_wstrb),
    .m_bvalid      (m_bvalid),
    .m_bready      (m_bready),
    .m_bresp       (m_bresp),
    .src_tdata     (src_tdata),
    .src_tvalid    (src_tvalid),
    .src_tready    (src_tready),
    .acc_in_tdata  (acc_in_tdata),
    .acc_in_tvalid (acc_in_tvalid),
    .acc_in_tready (acc_in_tready),
    .acc_in_tlast  (acc_in_tlast),
    .acc_out_tdata (acc_out_tdata),
    .acc_out_tvalid(acc_out_tvalid),
    .acc_out_tready(acc_out_tready),
    .dst_tdata     (dst_tdata),
    .dst_tvalid    (dst_tvalid),
    .dst_tready    (dst_tready)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Handshake and pulse counters observed at the active edge
  always @(posedge ap_clk) begin
    if (m_awvalid && m_awready) aw_hs <= aw_hs + 1;
    if (m_wvalid && m_wready)   w_hs  <= w_hs + 1;
    if (done)                   done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start pulse and AXI-lite config write; m_awready held off for aw_lat cycles
  task automatic cfg(input string tg, input int aw_lat);
    m_wready  = 1'b1;
    m_awready = (aw_lat == 0);
    start     = 1'b1;
    @(negedge ap_clk);
    chk({tg, ".aw_pre"}, m_awvalid, 1'b0);
    @(posedge ap_clk); #1;
    start = 1'b0;
    for (int c = 0; c <= aw_lat; c++) begin
      if (c == aw_lat) m_awready = 1'b1;
      @(negedge ap_clk);
      chk({tg, ".awvalid"}, m_awvalid, 1'b1);
      chk({tg, ".wvalid"},  m_wvalid, (c == 0));
      chk({tg, ".bready0"}, m_bready, 1'b0);
      chk({tg, ".busy"},    busy, 1'b1);
      chk({tg, ".err0"},    err, 1'b0);
      chk({tg, ".awaddr"},  m_awaddr, 5'h00);
      chk({tg, ".wdata"},   m_wdata, 32'h1);
      chk({tg, ".wstrb"},   m_wstrb, 4'hF);
      @(posedge ap_clk); #1;
    end
    @(negedge ap_clk);
    chk({tg, ".aw_drop"}, m_awvalid, 1'b0);
    chk({tg, ".w_drop"},  m_wvalid, 1'b0);
    chk({tg, ".bready1"}, m_bready, 1'b1);
    @(posedge ap_clk); #1;
  endtask

  task automatic resp(input logic [1:0] r);
    m_bvalid = 1'b1;
    m_bresp  = r;
    @(negedge ap_clk);
    chk("resp.bready", m_bready, 1'b1);
    @(posedge ap_clk); #1;
    m_bvalid = 1'b0;
    m_bresp  = 2'b00;
  endtask

  // Full frame from RUN; accelerator output starts at cycle ostart of the frame
  task automatic stream(input string tg, input int ostart);
    int ib = 0;
    int ob = 0;
    int cyc = 0;
    int d0 = done_cnt;
    src_tvalid = 1'b1;
    while (ob < 9 && cyc < 200) begin
      src_tdata      = 8'(ib + 8'h10);
      acc_out_tvalid = (cyc >= ostart);
      acc_out_tdata  = 8'(8'hA0 + ob);
      @(negedge ap_clk);
      if (ib < 16) begin
        chk({tg, ".in_valid"}, acc_in_tvalid, 1'b1);
        chk({tg, ".in_data"},  acc_in_tdata, 8'(ib + 8'h10));
        chk({tg, ".tlast"},    acc_in_tlast, (ib == 15));
      end else begin
        chk({tg, ".src_block"}, src_tready, 1'b0);
        chk({tg, ".in_block"},  acc_in_tvalid, 1'b0);
      end
      if (acc_out_tvalid) begin
        chk({tg, ".dst_valid"}, dst_tvalid, 1'b1);
        chk({tg, ".dst_data"},  dst_tdata, 8'(8'hA0 + ob));
        chk({tg, ".out_ready"}, acc_out_tready, 1'b1);
      end
      chk({tg, ".busy_run"}, busy, 1'b1);
      chk({tg, ".err_run"},  err, 1'b0);
      chk({tg, ".no_done"},  done, 1'b0);
      @(posedge ap_clk); #1;
      if (ib < 16) ib++;
      if (acc_out_tvalid) ob++;
      cyc++;
    end
    chk({tg, ".beats_in_budget"}, ob, 9);
    @(negedge ap_clk);
    chk({tg, ".done1"},      done, 1'b1);
    chk({tg, ".busy_fin"},   busy, 1'b1);
    chk({tg, ".dst_gated"},  dst_tvalid, 1'b0);
    chk({tg, ".src_gated"},  src_tready, 1'b0);
    @(posedge ap_clk); #1;
    @(negedge ap_clk);
    chk({tg, ".done0"},      done, 1'b0);
    chk({tg, ".busy_idle"},  busy, 1'b0);
    chk({tg, ".dst_idle"},   dst_tvalid, 1'b0);
    chk({tg, ".done_count"}, done_cnt - d0, 1);
    @(posedge ap_clk); #1;
    src_tvalid     = 1'b0;
    acc_out_tvalid = 1'b0;
  endtask

  initial begin
    int aw0;
    int w0;
    int d0;
    ap_rst_n = 1'b0; start = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
    m_bvalid = 1'b0; m_bresp = 2'b00; src_tdata = 8'h0; src_tvalid = 1'b0;
    acc_in_tready = 1'b0; acc_out_tdata = 8'h0; acc_out_tvalid = 1'b0; dst_tready = 1'b0;
    #12;
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.err", err, 1'b0);
    chk("rst.awvalid", m_awvalid, 1'b0);
    chk("rst.wvalid", m_wvalid, 1'b0);
    chk("rst.bready", m_bready, 1'b0);
    chk("rst.src_tready", src_tready, 1'b0);
    chk("rst.in_valid", acc_in_tvalid, 1'b0);
    chk("rst.dst_valid", dst_tvalid, 1'b0);
    chk("rst.out_ready", acc_out_tready, 1'b0);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1; acc_in_tready = 1'b1; dst_tready = 1'b1;
    @(posedge ap_clk); #1;

    // Nominal frame: input completes, then drain
    aw0 = aw_hs; w0 = w_hs;
    cfg("nom", 0);
    resp(2'b00);
    stream("nom", 16);
    chk("nom.aw_writes", aw_hs - aw0, 1);
    chk("nom.w_writes", w_hs - w0, 1);

    // Last input and last output in the same cycle
    cfg("coin", 0);
    resp(2'b00);
    stream("coin", 7);

    // Delayed m_awready
    aw0 = aw_hs; w0 = w_hs;
    cfg("awdly", 3);
    chk("awdly.aw_writes", aw_hs - aw0, 1);
    chk("awdly.w_writes", w_hs - w0, 1);
    resp(2'b00);
    stream("awdly", 16);

    // SLVERR response, then recovery by start
    cfg("slverr", 0);
    resp(2'b10);
    src_tvalid = 1'b1; acc_out_tvalid = 1'b1;
    @(negedge ap_clk);
    chk("slverr.err", err, 1'b1);
    chk("slverr.busy", busy, 1'b0);
    chk("slverr.src_tready", src_tready, 1'b0);
    chk("slverr.in_valid", acc_in_tvalid, 1'b0);
    chk("slverr.dst_valid", dst_tvalid, 1'b0);
    chk("slverr.out_ready", acc_out_tready, 1'b0);
    chk("slverr.bready", m_bready, 1'b0);
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("slverr.sticky", err, 1'b1);
    @(posedge ap_clk); #1;
    src_tvalid = 1'b0; acc_out_tvalid = 1'b0;
    cfg("rec", 0);
    resp(2'b00);
    stream("rec", 16);

    // Reset pulsed after 7 input beats
    cfg("rstmid", 0);
    resp(2'b00);
    d0 = done_cnt;
    src_tvalid = 1'b1; acc_out_tvalid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      src_tdata = 8'(i);
      @(posedge ap_clk); #1;
    end
    @(negedge ap_clk);
    chk("rstmid.in_valid_pre", acc_in_tvalid, 1'b1);
    #1 ap_rst_n = 1'b0;
    #1;
    chk("rstmid.in_valid", acc_in_tvalid, 1'b0);
    chk("rstmid.src_tready", src_tready, 1'b0);
    chk("rstmid.dst_valid", dst_tvalid, 1'b0);
    chk("rstmid.busy", busy, 1'b0);
    chk("rstmid.done", done, 1'b0);
    chk("rstmid.err", err, 1'b0);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1; src_tvalid = 1'b0; acc_out_tvalid = 1'b0;
    repeat (3) begin
      @(negedge ap_clk);
      chk("rstmid.idle_busy", busy, 1'b0);
      chk("rstmid.idle_aw", m_awvalid, 1'b0);
      @(posedge ap_clk); #1;
    end
    chk("rstmid.no_done", done_cnt - d0, 0);
    cfg("after_rst", 0);
    resp(2'b00);
    stream("after_rst", 16);

`ifdef GB_FRAME_CTRL_TIMEOUT_EN
    // Output stalls in DRAIN until the watchdog fires
    cfg("wdog", 0);
    resp(2'b00);
    src_tvalid = 1'b1; acc_out_tvalid = 1'b0;
    repeat (16) begin
      @(posedge ap_clk); #1;
    end
    for (int d = 1; d <= 32; d++) begin
      @(negedge ap_clk);
      chk("wdog.err_pre", err, 1'b0);
      @(posedge ap_clk); #1;
    end
    @(negedge ap_clk);
    chk("wdog.err", err, 1'b1);
    chk("wdog.busy", busy, 1'b0);
    @(posedge ap_clk); #1;
    src_tvalid = 1'b0;
    cfg("wdrec", 0);
    resp(2'b00);
    stream("wdrec", 16);
`else
    // Long output stall without watchdog: frame still completes cleanly
    cfg("nowd", 0);
    resp(2'b00);
    stream("nowd", 56);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
